// File: rtl/shift_reg_sequencer_if.sv
// Word-level request/response bundle between a requester and shift_reg_sequencer.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic [WIDTH-1:0] tx_word;
    logic [CNT_W-1:0] len;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] rx_word;

    modport master (
        output start, tx_word, len,
        input  ready, done, rx_word
    );

    modport slave (
        input  start, tx_word, len,
        output ready, done, rx_word
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Sequences an external chained shift register through load / N-cycle shift / readback.
// Optional SRSEQ_ABORT_EN adds an abort input and a one-cycle aborted pulse.
module shift_reg_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_sequencer_if.slave req,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_en,
    output logic             sr_mode,
    output logic             sr_sin,
    output logic [WIDTH-1:0] sr_p_in,
    input  logic             sr_sout,
    input  logic [WIDTH-1:0] sr_status
`ifdef SRSEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] rx_now;
    logic [WIDTH-1:0] rx_mask;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_eff;
`ifdef SRSEQ_ABORT_EN
    logic             abort_hit;
`endif

    // A length of zero or beyond the register width means a full-width transfer.
    assign len_eff = (req.len == '0 || req.len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : req.len;
    assign rx_mask = (len_q == CNT_W'(WIDTH)) ? '1 : ((WIDTH'(1) << len_q) - WIDTH'(1));
    assign rx_now  = sr_status & rx_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
`ifdef SRSEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE:    if (req.start) begin
                             tx_q  <= req.tx_word;
                             len_q <= len_eff;
                         end
                LOAD:    cnt_q <= '0;
                SHIFT:   cnt_q <= cnt_q + CNT_W'(1);
                DONE:    rx_q  <= rx_now;
                default: ;
            endcase
`ifdef SRSEQ_ABORT_EN
            aborted <= abort_hit;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        req.ready   = 1'b0;
        req.done    = 1'b0;
        req.rx_word = rx_q;
        ser_en      = 1'b0;
        ser_out     = 1'b0;
        sr_mode     = 1'b1;
        sr_sin      = 1'b0;
        sr_p_in     = sr_status;
        case (state_q)
            IDLE: begin
                req.ready = 1'b1;
                if (req.start) state_d = LOAD;
            end
            LOAD: begin
                sr_p_in = tx_q;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_mode = 1'b0;
                sr_sin  = ser_in;
                ser_out = sr_sout;
                ser_en  = 1'b1;
                if (cnt_q == len_q - CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                // Present the masked word during the done pulse itself; rx_q keeps it afterwards.
                req.done    = 1'b1;
                req.rx_word = rx_now;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SRSEQ_ABORT_EN
        abort_hit = abort && (state_q == LOAD || state_q == SHIFT);
        if (abort_hit) state_d = IDLE;
`endif
    end

endmodule
